// File: rtl/tirage_collecteur_if.sv
// Bus bundle for tirage_collecteur: draw inputs, grid read port and status outputs.
interface tirage_collecteur_if;
  logic       Start;
  logic       TriggerTirage;
  logic [6:0] NbrTire;
  logic [2:0] RdIdx;
  logic [6:0] RdBoule;
  logic [6:0] Boule;
  logic       BouleValid;
  logic       Rejet;
  logic [3:0] NbAcceptes;
  logic       Occupe;
  logic       Fini;

  modport master (
    output Start, TriggerTirage, NbrTire, RdIdx,
    input  RdBoule, Boule, BouleValid, Rejet, NbAcceptes, Occupe, Fini
  );

  modport slave (
    input  Start, TriggerTirage, NbrTire, RdIdx,
    output RdBoule, Boule, BouleValid, Rejet, NbAcceptes, Occupe, Fini
  );
endinterface

// File: rtl/tirage_collecteur.sv
// Collects sampled draw values into a grid of NB_BOULES distinct numbers in 1..VAL_MAX.
// Build option: define TIRAGE_TRI_EN to keep the grid sorted ascending.
module tirage_collecteur #(
  parameter int unsigned NB_BOULES       = 6,
  parameter int unsigned VAL_MAX         = 49,
  parameter bit          POLARITY_TIRAGE = 1'b0
) (
  input logic                Clk,
  input logic                RstN,
  tirage_collecteur_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAttente, StControle, StFini} stateT;

  localparam logic [6:0] ValMax   = 7'(VAL_MAX);
  localparam logic [3:0] NbBoules = 4'(NB_BOULES);

  stateT        stateQ;
  logic         s1Q, s2Q, s3Q;
  logic         edgeFlag;
  logic [6:0]   candidatQ;
  logic [6:0]   gridQ [8];
  logic [6:0]   gridIns [8];
  logic [127:0] bitmapQ;
  logic [6:0]   bouleQ;
  logic         bouleValidQ, rejetQ, occupeQ, finiQ;
  logic [3:0]   nbAcceptesQ;
  logic         rejeter;

  // Synchroniser is deliberately not reset; IDLE ignores any edge seen while it settles.
  always_ff @(posedge Clk) begin
    s1Q <= bus.TriggerTirage;
    s2Q <= s1Q;
    s3Q <= s2Q;
  end

  assign edgeFlag = POLARITY_TIRAGE ? (s2Q & ~s3Q) : (~s2Q & s3Q);

  assign rejeter = (candidatQ == 7'd0) || (candidatQ > ValMax) || bitmapQ[candidatQ];

`ifdef TIRAGE_TRI_EN
  logic [7:0] gt;

  // Entries greater than the candidate move up one slot; candidate lands in the gap.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      gt[i]      = (4'(i) < nbAcceptesQ) && (gridQ[i] > candidatQ);
      gridIns[i] = gridQ[i];
    end
    if ((nbAcceptesQ == 4'd0) || gt[0]) begin
      gridIns[0] = candidatQ;
    end
    for (int i = 1; i < 8; i++) begin
      if ((4'(i) <= nbAcceptesQ) && ((4'(i) == nbAcceptesQ) || gt[i])) begin
        gridIns[i] = gt[i-1] ? gridQ[i-1] : candidatQ;
      end
    end
  end
`else
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      gridIns[i] = gridQ[i];
    end
    gridIns[nbAcceptesQ[2:0]] = candidatQ;
  end
`endif

  always_ff @(posedge Clk) begin
    if (!RstN) begin
      stateQ      <= StIdle;
      candidatQ   <= '0;
      bouleQ      <= '0;
      nbAcceptesQ <= '0;
      bitmapQ     <= '0;
      gridQ       <= '{default: '0};
      bouleValidQ <= 1'b0;
      rejetQ      <= 1'b0;
      occupeQ     <= 1'b0;
      finiQ       <= 1'b0;
    end else begin
      bouleValidQ <= 1'b0;
      rejetQ      <= 1'b0;
      if (bus.Start) begin
        // Start wins over everything, including a candidate pending in CONTROLE.
        bitmapQ     <= '0;
        gridQ       <= '{default: '0};
        nbAcceptesQ <= '0;
        stateQ      <= StAttente;
        occupeQ     <= 1'b1;
        finiQ       <= 1'b0;
      end else begin
        case (stateQ)
          StAttente: begin
            if (edgeFlag) begin
              candidatQ <= bus.NbrTire;
              stateQ    <= StControle;
            end
          end
          StControle: begin
            if (rejeter) begin
              rejetQ <= 1'b1;
              stateQ <= StAttente;
            end else begin
              gridQ              <= gridIns;
              bitmapQ[candidatQ] <= 1'b1;
              bouleQ             <= candidatQ;
              bouleValidQ        <= 1'b1;
              nbAcceptesQ        <= nbAcceptesQ + 4'd1;
              if (nbAcceptesQ + 4'd1 == NbBoules) begin
                stateQ  <= StFini;
                occupeQ <= 1'b0;
                finiQ   <= 1'b1;
              end else begin
                stateQ <= StAttente;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.RdBoule    = ({1'b0, bus.RdIdx} < nbAcceptesQ) ? gridQ[bus.RdIdx] : 7'd0;
  assign bus.Boule      = bouleQ;
  assign bus.BouleValid = bouleValidQ;
  assign bus.Rejet      = rejetQ;
  assign bus.NbAcceptes = nbAcceptesQ;
  assign bus.Occupe     = occupeQ;
  assign bus.Fini       = finiQ;

endmodule
